airlock_sequencer: RTL and testbench

- Control FSM for the interlock chamber: sequences pressurize/evacuate pump cycles and door lock releases.
- Arbitrates between the inner-side requester and the outer-side requester, both already-debounced active-high pulses or levels.
- Sits between the board key/switch conditioning logic and the chamber actuators/LED outputs.
- Guarantees at most one door is unlocked at any time and no pump runs with a door open.

---
 rtl/airlock_sequencer.sv | 152 +++++++++++++++
 tb/tb_airlock_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/airlock_sequencer.sv
// Airlock interlock sequencer: pump cycles, door lock releases and side arbitration.
// Define AIRLOCK_DOOR_TIMEOUT_EN to enable the door-held-open alarm (door_alarm).
module airlock_sequencer #(
    parameter int unsigned EVAC_CYCLES  = 8,
    parameter int unsigned PRESS_CYCLES = 6,
`ifdef AIRLOCK_DOOR_TIMEOUT_EN
    parameter int unsigned DOOR_TIMEOUT = 16,
`endif
    parameter int unsigned CNT_W        = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       req_inner,
    input  logic       req_outer,
    input  logic       inner_open,
    input  logic       outer_open,
    output logic       inner_unlock,
    output logic       outer_unlock,
    output logic       pump_press,
    output logic       pump_evac,
    output logic       grant_inner,
    output logic       grant_outer,
    output logic       busy,
    output logic       fault,
    output logic       door_alarm,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StInit      = 3'd0,
        StPress     = 3'd1,
        StPressIdle = 3'd2,
        StEvac      = 3'd3,
        StEvacIdle  = 3'd4,
        StFault     = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] PressLast = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] EvacLast  = CNT_W'(EVAC_CYCLES - 1);

    state_e           st_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_in_q, pend_out_q;
    logic             pend_in_d, pend_out_d;
    logic             any_open;
    logic             alarm;
    logic [CNT_W-1:0] idle_cnt;

    assign any_open = inner_open | outer_open;

    assign pend_in_d  = (pend_in_q | req_inner) & ~grant_inner;
    assign pend_out_d = (pend_out_q | req_outer) & ~grant_outer;

`ifdef AIRLOCK_DOOR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] DoorLimit = CNT_W'(DOOR_TIMEOUT);

    assign alarm = ((st_q == StPressIdle) || (st_q == StEvacIdle)) && (cnt_q >= DoorLimit);

    // Idle counter tracks consecutive open cycles of the unlocked door, saturating at the limit.
    always_comb begin
        idle_cnt = '0;
        if (((st_q == StPressIdle) && inner_open) || ((st_q == StEvacIdle) && outer_open)) begin
            idle_cnt = (cnt_q >= DoorLimit) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end
`else
    assign alarm    = 1'b0;
    assign idle_cnt = '0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            st_q       <= StInit;
            cnt_q      <= '0;
            pend_in_q  <= 1'b0;
            pend_out_q <= 1'b0;
        end else begin
            pend_in_q  <= pend_in_d;
            pend_out_q <= pend_out_d;
            case (st_q)
                StInit: begin
                    cnt_q <= '0;
                    if (!any_open) st_q <= StPress;
                end
                StPress: begin
                    if (any_open) begin
                        st_q  <= StFault;
                        cnt_q <= '0;
                    end else if (cnt_q == PressLast) begin
                        st_q  <= StPressIdle;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StEvac: begin
                    if (any_open) begin
                        st_q  <= StFault;
                        cnt_q <= '0;
                    end else if (cnt_q == EvacLast) begin
                        st_q  <= StEvacIdle;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                // An inner grant issued this cycle clears pend_in_d, so only a fresh request waits.
                StPressIdle: begin
                    if (outer_open) begin
                        st_q  <= StFault;
                        cnt_q <= '0;
                    end else if (pend_out_q && !pend_in_d && !any_open && !alarm) begin
                        st_q  <= StEvac;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= idle_cnt;
                    end
                end
                StEvacIdle: begin
                    if (inner_open) begin
                        st_q  <= StFault;
                        cnt_q <= '0;
                    end else if (pend_in_q && !pend_out_d && !any_open && !alarm) begin
                        st_q  <= StPress;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= idle_cnt;
                    end
                end
                StFault: begin
                    st_q <= StFault;
                end
                default: begin
                    st_q  <= StInit;
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign state        = st_q;
    assign pump_press   = (st_q == StPress);
    assign pump_evac    = (st_q == StEvac);
    assign busy         = pump_press | pump_evac;
    assign inner_unlock = (st_q == StPressIdle);
    assign outer_unlock = (st_q == StEvacIdle);
    assign grant_inner  = inner_unlock & pend_in_q;
    assign grant_outer  = outer_unlock & pend_out_q;
    assign fault        = (st_q == StFault);
    assign door_alarm   = alarm;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: directed scenarios plus random stimulus against a
// cycle-level behavioural model (countdown pump timers, open-run counting).
module tb_airlock_sequencer;

    localparam int EVAC  = 8;
    localparam int PRESS = 6;
    localparam int TMO   = 16;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       req_inner = 1'b0, req_outer = 1'b0;
    logic       inner_open = 1'b0, outer_open = 1'b0;
    logic       inner_unlock, outer_unlock, pump_press, pump_evac;
    logic       grant_inner, grant_outer, busy, fault, door_alarm;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 init, 1 pressurizing, 2 press idle, 3 evacuating, 4 evac idle, 5 fault.
    int m_st, m_left, m_run;
    bit m_pin, m_pout;

    logic [2:0] o_state;
    logic o_iu, o_ou, o_pp, o_pe, o_gi, o_go, o_busy, o_fault, o_alarm;

    always #5 Clock = ~Clock;

    airlock_sequencer dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req_inner   (req_inner),
        .req_outer   (req_outer),
        .inner_open  (inner_open),
        .outer_open  (outer_open),
        .inner_unlock(inner_unlock),
        .outer_unlock(outer_unlock),
        .pump_press  (pump_press),
        .pump_evac   (pump_evac),
        .grant_inner (grant_inner),
        .grant_outer (grant_outer),
        .busy        (busy),
        .fault       (fault),
        .door_alarm  (door_alarm),
        .state       (state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_alarm();
`ifdef AIRLOCK_DOOR_TIMEOUT_EN
        return ((m_st == 2) || (m_st == 4)) && (m_run >= TMO);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [11:0] model_vec();
        bit iu, ou, pp, pe;
        iu = (m_st == 2);
        ou = (m_st == 4);
        pp = (m_st == 1);
        pe = (m_st == 3);
        return {3'(m_st), iu, ou, pp, pe, iu && m_pin, ou && m_pout, pp || pe, m_st == 5,
                model_alarm()};
    endfunction

    task automatic model_reset();
        m_st = 0; m_left = 0; m_run = 0; m_pin = 0; m_pout = 0;
    endtask

    task automatic model_step();
        bit gi, go, alarm, pin_n, pout_n, closed;
        if (Reset) begin
            model_reset();
            return;
        end
        gi     = (m_st == 2) && m_pin;
        go     = (m_st == 4) && m_pout;
        alarm  = model_alarm();
        pin_n  = (m_pin || req_inner) && !gi;
        pout_n = (m_pout || req_outer) && !go;
        closed = !inner_open && !outer_open;
        case (m_st)
            0: if (closed) begin m_st = 1; m_left = PRESS; end
            1, 3: begin
                if (!closed) m_st = 5;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_st  = (m_st == 1) ? 2 : 4;
                        m_run = 0;
                    end
                end
            end
            2: begin
                if (outer_open) m_st = 5;
                else if (m_pout && !pin_n && closed && !alarm) begin m_st = 3; m_left = EVAC; end
                else m_run = inner_open ? m_run + 1 : 0;
            end
            4: begin
                if (inner_open) m_st = 5;
                else if (m_pin && !pout_n && closed && !alarm) begin m_st = 1; m_left = PRESS; end
                else m_run = outer_open ? m_run + 1 : 0;
            end
            default: ;
        endcase
        m_pin  = pin_n;
        m_pout = pout_n;
    endtask

    // Sample one cycle on the falling edge, compare to the model, then advance both.
    task automatic tick();
        logic [11:0] got;
        @(negedge Clock);
        got = {state, inner_unlock, outer_unlock, pump_press, pump_evac, grant_inner,
               grant_outer, busy, fault, door_alarm};
        {o_state, o_iu, o_ou, o_pp, o_pe, o_gi, o_go, o_busy, o_fault, o_alarm} = got;
        check_eq("outputs", 32'(got), 32'(model_vec()));
        @(posedge Clock);
        model_step();
        #1;
    endtask

    task automatic wait_state(input int target, input int budget, input string tag);
        int n;
        tick();
        n = 1;
        while ((32'(o_state) != target) && (n < budget)) begin
            tick();
            n++;
        end
        if (32'(o_state) != target) check_eq({tag, "_timeout"}, 32'(o_state), 32'(target));
    endtask

    task automatic test_reset_seq();
        int n;
        Reset = 1; req_inner = 0; req_outer = 0; inner_open = 0; outer_open = 0;
        repeat (3) tick();
        Reset = 0;
        tick();
        check_eq("t1_init_state", 32'(o_state), 0);
        check_eq("t1_init_outs", 32'({o_pp, o_pe, o_iu, o_ou, o_busy}), 0);
        n = 0;
        repeat (PRESS) begin tick(); n += int'(o_pp); end
        check_eq("t1_press_len", 32'(n), 32'(PRESS));
        tick();
        check_eq("t1_idle_state", 32'(o_state), 2);
        check_eq("t1_inner_unlock", 32'(o_iu), 1);
    endtask

    initial begin
        int n;
        int first;
        Reset = 1;
        repeat (2) @(posedge Clock);
        #1;
        model_reset();

        test_reset_seq();

        // Outer request from pressurized idle.
        req_outer = 1; tick(); req_outer = 0;
        tick();
        check_eq("t2_pre_state", 32'(o_state), 2);
        n = 0;
        repeat (EVAC) begin tick(); n += int'(o_pe & o_busy & ~o_iu); end
        check_eq("t2_evac_len", 32'(n), 32'(EVAC));
        tick();
        check_eq("t2_evac_idle", 32'(o_state), 4);
        check_eq("t2_outer_unlock", 32'(o_ou), 1);
        check_eq("t2_grant_outer", 32'(o_go), 1);
        tick();
        check_eq("t2_grant_once", 32'(o_go), 0);

        // Simultaneous requests in pressurized idle: inner first, then evacuate.
        req_inner = 1; tick(); req_inner = 0;
        wait_state(2, 20, "t3_setup");
        req_inner = 1; req_outer = 1; tick(); req_inner = 0; req_outer = 0;
        tick();
        check_eq("t3_grant_inner", 32'(o_gi), 1);
        tick();
        check_eq("t3_evac_state", 32'(o_state), 3);
        wait_state(4, 20, "t3_evac_done");
        check_eq("t3_grant_outer", 32'(o_go), 1);

        // Unlocked door held open blocks evacuation.
        req_inner = 1; tick(); req_inner = 0;
        wait_state(2, 20, "t4_setup");
        inner_open = 1; req_outer = 1; tick(); req_outer = 0;
        repeat (4) tick();
        check_eq("t4_held", 32'(o_state), 2);
        inner_open = 0;
        tick();
        check_eq("t4_still_idle", 32'(o_state), 2);
        tick();
        check_eq("t4_evac_start", 32'(o_state), 3);

        // Door opened mid-evacuation latches the fault.
        tick(); tick();
        outer_open = 1; tick();
        check_eq("t5_cycle4_state", 32'(o_state), 3);
        outer_open = 0;
        tick();
        check_eq("t5_fault_state", 32'(o_state), 5);
        check_eq("t5_fault_flag", 32'(o_fault), 1);
        check_eq("t5_actuators_off", 32'({o_pp, o_pe, o_iu, o_ou}), 0);
        repeat (5) tick();
        check_eq("t5_latched", 32'(o_state), 5);
        test_reset_seq();

`ifdef AIRLOCK_DOOR_TIMEOUT_EN
        req_outer = 1; tick(); req_outer = 0;
        wait_state(4, 20, "t6_setup");
        outer_open = 1;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_alarm && first < 0) first = i;
        end
        check_eq("t6_alarm_rise", 32'(first), 32'(TMO));
        outer_open = 0;
        tick();
        check_eq("t6_alarm_hold", 32'(o_alarm), 1);
        tick();
        check_eq("t6_alarm_clear", 32'(o_alarm), 0);
`endif

        // Random traffic; door activity concentrated on the currently unlocked side.
        for (int c = 0; c < 4000; c++) begin
            req_inner = ($urandom_range(7) == 0);
            req_outer = ($urandom_range(7) == 0);
            if (m_st == 2) begin
                if ($urandom_range(9) == 0) inner_open = ~inner_open;
                outer_open = ($urandom_range(299) == 0);
            end else if (m_st == 4) begin
                if ($urandom_range(9) == 0) outer_open = ~outer_open;
                inner_open = ($urandom_range(299) == 0);
            end else begin
                inner_open = ($urandom_range(299) == 0);
                outer_open = ($urandom_range(299) == 0);
            end
            Reset = ((m_st == 5) && ($urandom_range(3) == 0)) || ($urandom_range(499) == 0);
            tick();
        end
        Reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
